vend_output_ctrl: RTL and testbench

//  Consumer of the vending FSM's single-cycle dispense / change_5 pulses.

---
 rtl/vend_pkg.sv | 22 ++
 rtl/vend_timer.sv | 27 ++
 rtl/vend_output_ctrl.sv | 150 +++++++++++++++
 tb/tb_vend_output_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types and constants for the vending output controller
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOTOR,
    ST_HOP_PULSE,
    ST_HOP_WAIT,
    ST_FAULT
  } vend_out_state_t;

  localparam int COIN_VALUE = 5;
  localparam int PRICE      = 15;

  // Largest of three limits, used to size the shared state timer
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/vend_timer.sv
// rtl/vend_timer.sv - loadable down-counter with expired flag for timed states
module vend_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] count_q;

  // Reload on state entry, otherwise count down and hold at zero
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/vend_output_ctrl.sv
// rtl/vend_output_ctrl.sv - queues dispense/change pulses and drives motor and hopper; HOPPER_RETRY_EN enables one hopper retry per job
module vend_output_ctrl
  import vend_pkg::*;
#(
  parameter int MAX_PENDING      = 4,
  parameter int MOTOR_TIMEOUT    = 200,
  parameter int HOPPER_PULSE_CYC = 3,
  parameter int HOPPER_TIMEOUT   = 50,
  localparam int PW = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          dispense_i,
  input  logic          change_5_i,
  input  logic          motor_done_i,
  input  logic          coin_out_sense_i,
  output logic          motor_on_o,
  output logic          hopper_pulse_o,
  output logic          busy_o,
  output logic          overflow_o,
  output logic          fault_o,
  output logic [PW-1:0] pend_vend_o,
  output logic [PW-1:0] pend_change_o
);

  localparam int            TMAX  = max3(MOTOR_TIMEOUT, HOPPER_PULSE_CYC, HOPPER_TIMEOUT);
  localparam int            TW    = $clog2(TMAX + 1);
  localparam logic [PW-1:0] MAX_P = PW'(MAX_PENDING);

  vend_out_state_t state_q, state_d;
  logic [PW-1:0]   pend_vend_q, pend_vend_d;
  logic [PW-1:0]   pend_change_q, pend_change_d;
  logic            motor_on_q, hopper_pulse_q, busy_q, overflow_q, fault_q;
  logic            vend_inc, vend_dec, chg_inc, chg_dec, drop;
  logic            timer_load, timer_expired;
  logic [TW-1:0]   timer_val;
`ifdef HOPPER_RETRY_EN
  logic            retry_q, retry_d;
`endif

  vend_timer #(.W(TW)) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .expired_o  (timer_expired)
  );

  // Next state, queue updates and timer reload; timer restarts on every state change
  always_comb begin
    state_d  = state_q;
    vend_dec = 1'b0;
    chg_dec  = 1'b0;
    vend_inc = dispense_i && (pend_vend_q != MAX_P);
    chg_inc  = change_5_i && (pend_change_q != MAX_P);
    drop     = (dispense_i && (pend_vend_q == MAX_P)) ||
               (change_5_i && (pend_change_q == MAX_P));
`ifdef HOPPER_RETRY_EN
    retry_d  = retry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pend_vend_q != '0) begin
          state_d  = ST_MOTOR;
          vend_dec = 1'b1;
        end else if (pend_change_q != '0) begin
          state_d = ST_HOP_PULSE;
          chg_dec = 1'b1;
`ifdef HOPPER_RETRY_EN
          retry_d = 1'b0;
`endif
        end
      end
      ST_MOTOR: begin
        if (motor_done_i)       state_d = ST_IDLE;
        else if (timer_expired) state_d = ST_FAULT;
      end
      ST_HOP_PULSE: begin
        if (timer_expired) state_d = ST_HOP_WAIT;
      end
      ST_HOP_WAIT: begin
        if (coin_out_sense_i) begin
          state_d = ST_IDLE;
        end else if (timer_expired) begin
`ifdef HOPPER_RETRY_EN
          if (!retry_q) begin
            state_d = ST_HOP_PULSE;
            retry_d = 1'b1;
          end else begin
            state_d = ST_FAULT;
          end
`else
          state_d = ST_FAULT;
`endif
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase

    pend_vend_d   = pend_vend_q + PW'(vend_inc) - PW'(vend_dec);
    pend_change_d = pend_change_q + PW'(chg_inc) - PW'(chg_dec);

    timer_load = (state_d != state_q);
    case (state_d)
      ST_MOTOR:     timer_val = TW'(MOTOR_TIMEOUT - 1);
      ST_HOP_PULSE: timer_val = TW'(HOPPER_PULSE_CYC - 1);
      ST_HOP_WAIT:  timer_val = TW'(HOPPER_TIMEOUT - 1);
      default:      timer_val = '0;
    endcase
  end

  // FSM state, queue counters and registered outputs derived from the next state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      pend_vend_q    <= '0;
      pend_change_q  <= '0;
      motor_on_q     <= 1'b0;
      hopper_pulse_q <= 1'b0;
      busy_q         <= 1'b0;
      overflow_q     <= 1'b0;
      fault_q        <= 1'b0;
`ifdef HOPPER_RETRY_EN
      retry_q        <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      pend_vend_q    <= pend_vend_d;
      pend_change_q  <= pend_change_d;
      motor_on_q     <= (state_d == ST_MOTOR);
      hopper_pulse_q <= (state_d == ST_HOP_PULSE);
      fault_q        <= (state_d == ST_FAULT);
      busy_q         <= (state_d != ST_IDLE) || (pend_vend_d != '0) || (pend_change_d != '0);
      overflow_q     <= overflow_q | drop;
`ifdef HOPPER_RETRY_EN
      retry_q        <= retry_d;
`endif
    end
  end

  assign motor_on_o     = motor_on_q;
  assign hopper_pulse_o = hopper_pulse_q;
  assign busy_o         = busy_q;
  assign overflow_o     = overflow_q;
  assign fault_o        = fault_q;
  assign pend_vend_o    = pend_vend_q;
  assign pend_change_o  = pend_change_q;

endmodule

// File: tb/tb_vend_output_ctrl.sv
// tb/tb_vend_output_ctrl.sv - vector table plus timeout sequences for vend_output_ctrl
module tb_vend_output_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dispense = 1'b0, change_5 = 1'b0, motor_done = 1'b0, coin_out_sense = 1'b0;
  logic       motor_on, hopper_pulse, busy, overflow, fault;
  logic [2:0] pend_vend, pend_change;

  int n_vec  = 0;
  int n_fail = 0;

`ifdef HOPPER_RETRY_EN
  localparam int EXP_HOP_CYC  = 6;
  localparam int EXP_WAIT_CYC = 100;
`else
  localparam int EXP_HOP_CYC  = 3;
  localparam int EXP_WAIT_CYC = 50;
`endif

  // inputs {rst,dispense,change_5,motor_done,coin_out_sense}
  // expected {motor_on,hopper_pulse,busy,overflow,fault,pend_vend[2:0],pend_change[2:0]}
  typedef struct {
    logic [4:0]  in;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];

  vend_output_ctrl dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .dispense_i       (dispense),
    .change_5_i       (change_5),
    .motor_done_i     (motor_done),
    .coin_out_sense_i (coin_out_sense),
    .motor_on_o       (motor_on),
    .hopper_pulse_o   (hopper_pulse),
    .busy_o           (busy),
    .overflow_o       (overflow),
    .fault_o          (fault),
    .pend_vend_o      (pend_vend),
    .pend_change_o    (pend_change)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [4:0] in);
    {rst, dispense, change_5, motor_done, coin_out_sense} = in;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [10:0] exp);
    logic [10:0] act;
    act = {motor_on, hopper_pulse, busy, overflow, fault, pend_vend, pend_change};
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] in, input logic [10:0] exp);
    vec_t v;
    v.in  = in;
    v.exp = exp;
    return v;
  endfunction

  initial begin
    int mcnt, hcnt, wcnt;

    // reset; dispense+change same cycle, motor job then hopper job
    vecs.push_back(mk(5'b10000, 11'b0_0_0_0_0_000_000));
    vecs.push_back(mk(5'b01100, 11'b0_0_1_0_0_001_001));
    vecs.push_back(mk(5'b00000, 11'b1_0_1_0_0_000_001));
    vecs.push_back(mk(5'b00000, 11'b1_0_1_0_0_000_001));
    vecs.push_back(mk(5'b00010, 11'b0_0_1_0_0_000_001));
    vecs.push_back(mk(5'b00000, 11'b0_1_1_0_0_000_000));
    vecs.push_back(mk(5'b00000, 11'b0_1_1_0_0_000_000));
    vecs.push_back(mk(5'b00000, 11'b0_1_1_0_0_000_000));
    vecs.push_back(mk(5'b00000, 11'b0_0_1_0_0_000_000));
    vecs.push_back(mk(5'b00001, 11'b0_0_0_0_0_000_000));
    vecs.push_back(mk(5'b00000, 11'b0_0_0_0_0_000_000));
    // six dispenses while motor stalled: saturate at 4, overflow
    vecs.push_back(mk(5'b01000, 11'b0_0_1_0_0_001_000));
    vecs.push_back(mk(5'b01000, 11'b1_0_1_0_0_001_000));
    vecs.push_back(mk(5'b01000, 11'b1_0_1_0_0_010_000));
    vecs.push_back(mk(5'b01000, 11'b1_0_1_0_0_011_000));
    vecs.push_back(mk(5'b01000, 11'b1_0_1_0_0_100_000));
    vecs.push_back(mk(5'b01000, 11'b1_0_1_1_0_100_000));
    // back-to-back jobs with one IDLE cycle, request accepted at 3
    vecs.push_back(mk(5'b00010, 11'b0_0_1_1_0_100_000));
    vecs.push_back(mk(5'b00000, 11'b1_0_1_1_0_011_000));
    vecs.push_back(mk(5'b01010, 11'b0_0_1_1_0_100_000));
    // reset mid hopper pulse clears everything and wins over requests
    vecs.push_back(mk(5'b10000, 11'b0_0_0_0_0_000_000));
    vecs.push_back(mk(5'b00100, 11'b0_0_1_0_0_000_001));
    vecs.push_back(mk(5'b00000, 11'b0_1_1_0_0_000_000));
    vecs.push_back(mk(5'b11100, 11'b0_0_0_0_0_000_000));
    vecs.push_back(mk(5'b00000, 11'b0_0_0_0_0_000_000));

    step(5'b10000);
    step(5'b10000);
    foreach (vecs[i]) begin
      step(vecs[i].in);
      check_out($sformatf("vec%0d", i), vecs[i].exp);
    end

    // motor timeout: motor_on for exactly 200 cycles, then sticky fault
    step(5'b10000);
    step(5'b01000);
    mcnt = 0;
    for (int k = 0; k < 400; k++) begin
      step(5'b00000);
      if (motor_on) mcnt++;
      if (fault) break;
    end
    check_int("motor_on_cycles", mcnt, 200);
    check_out("motor_fault", 11'b0_0_1_0_1_000_000);
    for (int k = 0; k < 5; k++) step(5'b01000);
    check_out("fault_queue_sat", 11'b0_0_1_1_1_100_000);
    step(5'b00000);
    check_out("fault_sticky", 11'b0_0_1_1_1_100_000);
    step(5'b10000);
    check_out("fault_reset", 11'b0_0_0_0_0_000_000);

    // hopper with no exit sensor
    step(5'b00100);
    hcnt = 0;
    wcnt = 0;
    for (int k = 0; k < 400; k++) begin
      step(5'b00000);
      if (hopper_pulse) hcnt++;
      else if (!fault && hcnt > 0) wcnt++;
      if (fault) break;
    end
    check_int("hopper_pulse_cycles", hcnt, EXP_HOP_CYC);
    check_int("hop_wait_cycles", wcnt, EXP_WAIT_CYC);
    check_out("hopper_fault", 11'b0_0_1_0_1_000_000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
